mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width (equals `ADDR_SIZE).
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive fetch denials before fetch is forced to win.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 iReq  input  1  fetch port request.
REQ-007 iAddr  input  ADDR_W  fetch address.
REQ-008 iGnt  output  1  fetch request accepted this cycle.
REQ-009 iRvalid  output  1  fetch read data valid.
REQ-010 iRdata  output  DATA_W  fetch read data.
REQ-011 dReq  input  1  data port request.
REQ-012 dWe  input  1  data port write (1) / read (0).
REQ-013 dAddr  input  ADDR_W  data address.
REQ-014 dWdata  input  DATA_W  write data.
REQ-015 dBe  input  DATA_W/8  byte enables for writes.
REQ-016 dGnt  output  1  data request accepted this cycle.
REQ-017 dRvalid  output  1  data access complete (read data valid or write acknowledged).
REQ-018 dRdata  output  DATA_W  data read data.
REQ-019 memEn, memWe  output  1 each  shared single-port RAM enable / write.
REQ-020 memAddr  output  ADDR_W; memWdata  output  DATA_W; memBe  output  DATA_W/8  RAM command.
REQ-021 memRdata  input  DATA_W  RAM read data, valid exactly one cycle after memEn.
REQ-022 stallF, stallM  output  1 each  pipeline stall requests for fetch / memory stage.

Function
REQ-023 The block SHALL grant at most one requester per cycle; iGnt and dGnt SHALL be combinational in the request cycle and never both high.
REQ-024 Default priority SHALL be data over fetch: dGnt = dReq when starveCnt < STARVE_LIMIT.
REQ-025 When starveCnt == STARVE_LIMIT and iReq is high, fetch SHALL win; dGnt low that cycle.
REQ-026 starveCnt (width ceil(log2(STARVE_LIMIT+1))) SHALL increment when iReq & !iGnt, saturate at STARVE_LIMIT, and clear to 0 when iGnt or !iReq.
REQ-027 memEn SHALL equal iGnt | dGnt; memAddr/memWdata/memBe SHALL come from the granted port (all zero when idle); memWe SHALL equal dGnt & dWe; fetch never writes.
REQ-028 Response FSM states IDLE, RESP_I, RESP_D, updated every cycle: next = RESP_D if dGnt, RESP_I if iGnt, else IDLE; any state may go to any state directly.
REQ-029 In RESP_I: iRvalid=1, iRdata=memRdata; in RESP_D: dRvalid=1, dRdata = memRdata for reads, 0 for writes (write flag registered with grant).
REQ-030 Rvalid/Rdata of a port not being responded to SHALL be 0.
REQ-031 Back-to-back grants SHALL be supported: a new grant and the previous response may occur in the same cycle; throughput one access per cycle.
REQ-032 stallF SHALL equal iReq & !iGnt; stallM SHALL equal dReq & !dGnt.
REQ-033 Requesters SHALL hold request and payload stable until granted; the block SHALL not buffer ungranted requests.

Reset
REQ-034 While reset is high: iGnt, dGnt, memEn, memWe SHALL be 0; FSM forced to IDLE; starveCnt cleared; all Rvalid 0; stall outputs 0.
REQ-035 Reset asserted with a response outstanding SHALL drop that response: no Rvalid in the cycle after reset deasserts unless a new grant occurred.
REQ-036 First grant SHALL be possible in the first cycle reset is low.

Verification
REQ-037 iReq=1, iAddr=0x80000000, RAM holds 0x00000013 -> iGnt same cycle, iRvalid=1, iRdata=0x00000013 next cycle, stallF=0.
REQ-038 iReq=dReq=1 simultaneously, dWe=0, dAddr=0x80001000 -> dGnt=1, iGnt=0, stallF=1; dRvalid next cycle with RAM word.
REQ-039 dReq held high 5 cycles with iReq high, STARVE_LIMIT=4 -> dGnt cycles 1-4, iGnt cycle 5, stallM=1 in cycle 5, starveCnt back to 0.
REQ-040 dWe=1, dAddr=0x80001004, dWdata=0xDEADBEEF, dBe=0xF then read same address -> memWe=1 once, dRvalid with dRdata=0 for write, read returns 0xDEADBEEF.
REQ-041 Alternating iGnt/dGnt every cycle for 8 cycles -> each Rvalid one cycle after its grant, no response lost or misrouted.
REQ-042 reset asserted in cycle after a grant -> no Rvalid while reset high or in first cycle after release without a new grant; starveCnt=0, FSM IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port RAM between instruction fetch and data access.
// Data wins by default; fetch is forced through after STARVE_LIMIT consecutive denials.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,

  // Fetch port
  input  logic                iReq,
  input  logic [ADDR_W-1:0]   iAddr,
  output logic                iGnt,
  output logic                iRvalid,
  output logic [DATA_W-1:0]   iRdata,

  // Data port
  input  logic                dReq,
  input  logic                dWe,
  input  logic [ADDR_W-1:0]   dAddr,
  input  logic [DATA_W-1:0]   dWdata,
  input  logic [DATA_W/8-1:0] dBe,
  output logic                dGnt,
  output logic                dRvalid,
  output logic [DATA_W-1:0]   dRdata,

  // Shared RAM
  output logic                memEn,
  output logic                memWe,
  output logic [ADDR_W-1:0]   memAddr,
  output logic [DATA_W-1:0]   memWdata,
  output logic [DATA_W/8-1:0] memBe,
  input  logic [DATA_W-1:0]   memRdata,

  // Pipeline stalls
  output logic                stallF,
  output logic                stallM
);

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    StIdle,
    StRespI,
    StRespD
  } state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

  logic            i_gnt, d_gnt;
  logic            fetch_forced;

  // ---------------------------------------------------------------------------
  // Grant arbitration (combinational in the request cycle)
  // ---------------------------------------------------------------------------
  assign fetch_forced = iReq && (starve_cnt_q == CntMax);

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (fetch_forced) begin
        i_gnt = 1'b1;
      end else if (dReq) begin
        d_gnt = 1'b1;
      end else if (iReq) begin
        i_gnt = 1'b1;
      end
    end
  end

  assign iGnt = i_gnt;
  assign dGnt = d_gnt;

  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles fetch waits while requesting
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (reset || i_gnt || !iReq) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < CntMax) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM command mux: zero when no port is granted
  // ---------------------------------------------------------------------------
  always_comb begin
    memEn    = 1'b0;
    memWe    = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    memBe    = '0;
    if (d_gnt) begin
      memEn    = 1'b1;
      memWe    = dWe;
      memAddr  = dAddr;
      memWdata = dWdata;
      memBe    = dBe;
    end else if (i_gnt) begin
      memEn    = 1'b1;
      memAddr  = iAddr;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FSM: the state simply records who was granted last cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = StIdle;
    we_d    = 1'b0;
    if (reset) begin
      state_d = StIdle;
    end else if (d_gnt) begin
      state_d = StRespD;
      we_d    = dWe;
    end else if (i_gnt) begin
      state_d = StRespI;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Responses are suppressed while reset is high so a pending one is dropped
  always_comb begin
    iRvalid = 1'b0;
    iRdata  = '0;
    dRvalid = 1'b0;
    dRdata  = '0;
    if (!reset) begin
      unique case (state_q)
        StRespI: begin
          iRvalid = 1'b1;
          iRdata  = memRdata;
        end
        StRespD: begin
          dRvalid = 1'b1;
          dRdata  = we_q ? '0 : memRdata;
        end
        default: ;
      endcase
    end
  end

  assign stallF = !reset && iReq && !i_gnt;
  assign stallM = !reset && dReq && !d_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM model with one-cycle read latency and
// hand-computed expectations for grant, response, starvation and reset behaviour.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              iReq;
  logic [ADDR_W-1:0] iAddr;
  logic              iGnt, iRvalid;
  logic [DATA_W-1:0] iRdata;
  logic              dReq, dWe;
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] dWdata;
  logic [3:0]        dBe;
  logic              dGnt, dRvalid;
  logic [DATA_W-1:0] dRdata;
  logic              memEn, memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [3:0]        memBe;
  logic [DATA_W-1:0] memRdata;
  logic              stallF, stallM;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .iReq     (iReq),
    .iAddr    (iAddr),
    .iGnt     (iGnt),
    .iRvalid  (iRvalid),
    .iRdata   (iRdata),
    .dReq     (dReq),
    .dWe      (dWe),
    .dAddr    (dAddr),
    .dWdata   (dWdata),
    .dBe      (dBe),
    .dGnt     (dGnt),
    .dRvalid  (dRvalid),
    .dRdata   (dRdata),
    .memEn    (memEn),
    .memWe    (memWe),
    .memAddr  (memAddr),
    .memWdata (memWdata),
    .memBe    (memBe),
    .memRdata (memRdata),
    .stallF   (stallF),
    .stallM   (stallM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model, word-indexed by address bits [13:2]
  logic [31:0] ram [0:4095];
  always @(posedge clk) begin
    if (memEn) begin
      if (memWe) begin
        for (int b = 0; b < 4; b++) begin
          if (memBe[b]) ram[memAddr[13:2]][8*b +: 8] <= memWdata[8*b +: 8];
        end
      end else begin
        memRdata <= ram[memAddr[13:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    ram[12'h000] = 32'h0000_0013;
    ram[12'h400] = 32'h1122_3344;
    memRdata = '0;
    reset = 1'b1;
    iReq = 1'b0; iAddr = '0;
    dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0; dBe = '0;

    // Reset: requests ignored
    cyc();
    iReq = 1'b1; dReq = 1'b1; iAddr = 32'h8000_0000; dAddr = 32'h8000_1000;
    settle();
    chk("rst_iGnt", iGnt, 0);
    chk("rst_dGnt", dGnt, 0);
    chk("rst_memEn", memEn, 0);
    chk("rst_memWe", memWe, 0);
    chk("rst_stallF", stallF, 0);
    chk("rst_stallM", stallM, 0);
    chk("rst_rvalid", {iRvalid, dRvalid}, 0);

    // First cycle out of reset: fetch alone is granted
    cyc();
    reset = 1'b0; dReq = 1'b0;
    settle();
    chk("f_iGnt", iGnt, 1);
    chk("f_dGnt", dGnt, 0);
    chk("f_stallF", stallF, 0);
    chk("f_memEn", memEn, 1);
    chk("f_memAddr", memAddr, 32'h8000_0000);
    chk("f_memWe", memWe, 0);

    cyc();
    iReq = 1'b0;
    settle();
    chk("f_iRvalid", iRvalid, 1);
    chk("f_iRdata", iRdata, 32'h0000_0013);
    chk("f_dRvalid", dRvalid, 0);
    chk("idle_memEn", memEn, 0);
    chk("idle_memAddr", memAddr, 0);

    // Simultaneous requests: data wins
    cyc();
    iReq = 1'b1; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h8000_1000;
    settle();
    chk("c_dGnt", dGnt, 1);
    chk("c_iGnt", iGnt, 0);
    chk("c_stallF", stallF, 1);
    chk("c_stallM", stallM, 0);
    chk("c_iRvalid", iRvalid, 0);
    chk("c_memAddr", memAddr, 32'h8000_1000);

    cyc();
    dReq = 1'b0;
    settle();
    chk("c_dRvalid", dRvalid, 1);
    chk("c_dRdata", dRdata, 32'h1122_3344);
    chk("c_iGnt2", iGnt, 1);

    cyc();
    iReq = 1'b0;
    settle();
    chk("c_iRvalid2", iRvalid, 1);
    chk("c_iRdata2", iRdata, 32'h0000_0013);
    chk("c_dRvalid2", dRvalid, 0);

    // Starvation: data wins 4 cycles, fetch forced on the 5th
    cyc();
    iReq = 1'b1; dReq = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk($sformatf("s_dGnt%0d", k), {dGnt, iGnt}, 2'b10);
      cyc();
    end
    settle();
    chk("s_iGnt5", {dGnt, iGnt}, 2'b01);
    chk("s_stallM5", stallM, 1);
    chk("s_stallF5", stallF, 0);
    chk("s_dRvalid5", dRvalid, 1);
    cyc();
    settle();
    chk("s_cnt_clr", {dGnt, iGnt}, 2'b10);
    chk("s_iRvalid6", iRvalid, 1);
    chk("s_iRdata6", iRdata, 32'h0000_0013);

    // Write then read back
    cyc();
    iReq = 1'b0; dReq = 1'b1; dWe = 1'b1;
    dAddr = 32'h8000_1004; dWdata = 32'hDEAD_BEEF; dBe = 4'hF;
    settle();
    chk("w_memWe", memWe, 1);
    chk("w_memWdata", memWdata, 32'hDEAD_BEEF);
    chk("w_memBe", memBe, 4'hF);
    chk("w_memAddr", memAddr, 32'h8000_1004);

    cyc();
    dWe = 1'b0; dWdata = '0; dBe = '0;
    settle();
    chk("w_dRvalid", dRvalid, 1);
    chk("w_dRdata0", dRdata, 0);
    chk("r_memWe", memWe, 0);
    chk("r_dGnt", dGnt, 1);

    cyc();
    dReq = 1'b0;
    settle();
    chk("r_dRvalid", dRvalid, 1);
    chk("r_dRdata", dRdata, 32'hDEAD_BEEF);

    // Alternating grants, responses checked against previous cycle's grant
    dAddr = 32'h8000_1000; iAddr = 32'h8000_0000;
    for (int k = 0; k < 8; k++) begin
      cyc();
      iReq = (k % 2 == 0);
      dReq = (k % 2 == 1);
      settle();
      chk($sformatf("a_gnt%0d", k), {dGnt, iGnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        if (k % 2 == 1) begin
          chk($sformatf("a_resp%0d", k), {iRvalid, dRvalid}, 2'b10);
          chk($sformatf("a_data%0d", k), iRdata, 32'h0000_0013);
        end else begin
          chk($sformatf("a_resp%0d", k), {iRvalid, dRvalid}, 2'b01);
          chk($sformatf("a_data%0d", k), dRdata, 32'h1122_3344);
        end
      end
    end
    cyc();
    iReq = 1'b0; dReq = 1'b0;
    settle();
    chk("a_last_resp", {iRvalid, dRvalid}, 2'b01);
    chk("a_last_data", dRdata, 32'h1122_3344);

    // Reset right after a grant drops the response
    cyc();
    iReq = 1'b1;
    settle();
    chk("x_iGnt", iGnt, 1);
    cyc();
    reset = 1'b1; iReq = 1'b0;
    settle();
    chk("x_rst_rvalid", {iRvalid, dRvalid}, 0);
    cyc();
    iReq = 1'b1; dReq = 1'b1;
    settle();
    chk("x_rst_gnt", {iGnt, dGnt}, 0);
    chk("x_rst_stall", {stallF, stallM}, 0);
    cyc();
    reset = 1'b0; iReq = 1'b0; dReq = 1'b0;
    settle();
    chk("x_rel_rvalid", {iRvalid, dRvalid}, 0);
    cyc();
    iReq = 1'b1; dReq = 1'b1;
    settle();
    chk("x_rel_rvalid2", {iRvalid, dRvalid}, 0);
    chk("x_cnt0_dGnt", {dGnt, iGnt}, 2'b10);
    cyc();
    iReq = 1'b0; dReq = 1'b0;
    settle();
    chk("x_new_resp", {iRvalid, dRvalid}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
